// File: rtl/fft_pkg.sv
// Shared types for the FFT frame adapter: complex sample payload, FSM states, log2 helper.
package fft_pkg;

    localparam int unsigned CPLX_W = 32;

    typedef struct packed {
        logic [CPLX_W-1:0] r;
        logic [CPLX_W-1:0] i;
    } complex_t;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        HOLD    = 2'd1,
        LAUNCH  = 2'd2,
        PRESENT = 2'd3
    } in_state_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } out_state_t;

    function automatic int unsigned log2n(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/fft_frame_serializer.sv
// Captures a core result frame (optionally 1/N scaled) and replays it as a valid/ready stream.
module fft_frame_serializer
    import fft_pkg::*;
#(
    parameter int unsigned N_POINTS  = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned SCALE_INV = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    core_next_out,
    input  logic                    inflight,
    input  logic                    core_inverse,
    input  complex_t [N_POINTS-1:0] core_out,
    input  logic                    out_ready,
    output logic                    out_valid,
    output complex_t                out_data,
    output logic                    out_last,
    output logic                    out_inverse,
    output logic                    drain_done_c
);

    localparam int unsigned CNT_W = $clog2(N_POINTS);
    localparam int unsigned LOG2N = log2n(N_POINTS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_POINTS - 1);

    out_state_t              r_state;
    logic [CNT_W-1:0]        r_ocnt;
    complex_t [N_POINTS-1:0] r_obuf;
    complex_t [N_POINTS-1:0] w_scaled;
    logic signed [DATA_W-1:0] w_sr [N_POINTS];
    logic signed [DATA_W-1:0] w_si [N_POINTS];
    logic                    w_scale;

    assign w_scale      = (SCALE_INV != 0) && core_inverse;
    assign drain_done_c = (r_state == DRAIN) && out_ready && (r_ocnt == LAST_IDX);

    // Arithmetic shift truncates toward minus infinity; forward frames bypass it.
    always_comb begin
        for (int j = 0; j < N_POINTS; j++) begin
            w_sr[j]     = $signed(core_out[j].r) >>> LOG2N;
            w_si[j]     = $signed(core_out[j].i) >>> LOG2N;
            w_scaled[j] = core_out[j];
            if (w_scale) begin
                w_scaled[j].r = w_sr[j];
                w_scaled[j].i = w_si[j];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_ocnt      <= '0;
            r_obuf      <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_inverse <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (core_next_out && inflight) begin
                        r_state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_obuf      <= w_scaled;
                    out_data    <= w_scaled[0];
                    out_valid   <= 1'b1;
                    out_last    <= (LAST_IDX == '0);
                    out_inverse <= core_inverse;
                    r_ocnt      <= '0;
                    r_state     <= DRAIN;
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (r_ocnt == LAST_IDX) begin
                            out_valid   <= 1'b0;
                            out_last    <= 1'b0;
                            out_inverse <= 1'b0;
                            out_data    <= '0;
                            r_state     <= IDLE;
                        end else begin
                            r_ocnt   <= r_ocnt + 1'b1;
                            out_data <= r_obuf[r_ocnt + 1'b1];
                            out_last <= ((r_ocnt + 1'b1) == LAST_IDX);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/fft_frame_stream.sv
// Gathers a serial sample stream into frames, launches the FFT core and streams results back out.
module fft_frame_stream
    import fft_pkg::*;
#(
    parameter int unsigned N_POINTS  = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned SCALE_INV = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  complex_t                in_data,
    input  logic                    in_last,
    input  logic                    in_inverse,
    output logic                    out_valid,
    input  logic                    out_ready,
    output complex_t                out_data,
    output logic                    out_last,
    output logic                    out_inverse,
    output logic                    len_err,
    output logic                    core_next,
    output logic                    core_inverse,
    output complex_t [N_POINTS-1:0] core_in,
    input  logic                    core_next_out,
    input  complex_t [N_POINTS-1:0] core_out
);

    localparam int unsigned CNT_W = $clog2(N_POINTS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_POINTS - 1);

    in_state_t               r_state;
    logic [CNT_W-1:0]        r_cnt;
    complex_t [N_POINTS-1:0] r_ibuf;
    logic                    r_inflight;
    logic                    r_frame_inv;
    logic                    w_accept;
    logic                    w_close;
    logic                    w_drain_done;

    assign w_accept = in_valid && in_ready;
    assign w_close  = w_accept && (in_last || (r_cnt == LAST_IDX));
    assign core_in  = r_ibuf;

    // Input FSM; in_ready is only ever high while in FILL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= FILL;
            r_cnt        <= '0;
            r_ibuf       <= '0;
            r_inflight   <= 1'b0;
            r_frame_inv  <= 1'b0;
            in_ready     <= 1'b0;
            len_err      <= 1'b0;
            core_next    <= 1'b0;
            core_inverse <= 1'b0;
        end else begin
            len_err   <= 1'b0;
            core_next <= 1'b0;
            if (w_drain_done) begin
                r_inflight <= 1'b0;
            end
            unique case (r_state)
                FILL: begin
                    in_ready <= !w_close;
                    if (w_accept) begin
                        for (int j = 0; j < N_POINTS; j++) begin
                            if (j == int'(r_cnt)) begin
                                r_ibuf[j] <= in_data;
                            end else if (w_close && (j > int'(r_cnt))) begin
                                r_ibuf[j] <= '0;
                            end
                        end
                        if (r_cnt == '0) begin
                            r_frame_inv <= in_inverse;
                        end
                        if (w_close) begin
                            len_err <= !in_last;
                            r_state <= HOLD;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!r_inflight) begin
                        core_next    <= 1'b1;
                        core_inverse <= r_frame_inv;
                        r_inflight   <= 1'b1;
                        r_state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_state <= PRESENT;
                end
                PRESENT: begin
                    r_cnt    <= '0;
                    in_ready <= 1'b1;
                    r_state  <= FILL;
                end
                default: r_state <= FILL;
            endcase
        end
    end

    fft_frame_serializer #(
        .N_POINTS  (N_POINTS),
        .DATA_W    (DATA_W),
        .SCALE_INV (SCALE_INV)
    ) u_serializer (
        .clk           (clk),
        .reset         (reset),
        .core_next_out (core_next_out),
        .inflight      (r_inflight),
        .core_inverse  (core_inverse),
        .core_out      (core_out),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_inverse   (out_inverse),
        .drain_done_c  (w_drain_done)
    );

endmodule

// File: tb/tb_fft_frame_stream.sv
// Directed bench for fft_frame_stream with an identity/constant core stub of latency 5.
module tb_fft_frame_stream;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    complex_t in_data = '0;
    logic in_last = 1'b0;
    logic in_inverse = 1'b0;
    logic out_valid;
    logic out_ready = 1'b0;
    complex_t out_data;
    logic out_last;
    logic out_inverse;
    logic len_err;
    logic core_next;
    logic core_inverse;
    complex_t [7:0] core_in;
    logic core_next_out;
    complex_t [7:0] core_out;

    logic [4:0] r_dly = '0;
    complex_t [7:0] r_stub = '0;
    complex_t [7:0] const_frame;
    logic stub_const = 1'b0;
    logic spur = 1'b0;
    int n_next = 0;
    int n_lenerr = 0;
    int n_checks = 0;
    int n_pass = 0;
    int base_next;
    int base_len;
    complex_t exp_q [8];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        r_dly <= {r_dly[3:0], core_next};
        if (core_next) r_stub <= core_in;
        if (core_next) n_next <= n_next + 1;
        if (len_err) n_lenerr <= n_lenerr + 1;
    end

    always_comb begin
        for (int j = 0; j < 8; j++) begin
            const_frame[j].r = 32'h0000_0080;
            const_frame[j].i = 32'hFFFF_FF80;
        end
    end

    assign core_next_out = r_dly[4] | spur;
    assign core_out = stub_const ? const_frame : r_stub;

    fft_frame_stream #(.N_POINTS(8), .DATA_W(32), .SCALE_INV(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_inverse    (in_inverse),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .out_inverse   (out_inverse),
        .len_err       (len_err),
        .core_next     (core_next),
        .core_inverse  (core_inverse),
        .core_in       (core_in),
        .core_next_out (core_next_out),
        .core_out      (core_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic complex_t cx(input int r, input int i);
        complex_t c;
        c.r = 32'(r);
        c.i = 32'(i);
        return c;
    endfunction

    // Sends nb beats r=rbase+k; in_inverse is inv only on beat 0 to prove first-beat sampling.
    task automatic send(input int nb, input int last_at, input int rbase, input bit imag_on, input logic inv);
        for (int k = 0; k < nb; k++) begin
            in_valid   = 1'b1;
            in_data    = cx(rbase + k, imag_on ? k + 1 : 0);
            in_last    = (k == last_at);
            in_inverse = (k == 0) ? inv : ~inv;
            for (int g = 0; g < 100 && !in_ready; g++) step();
            check("in_ready", 64'(in_ready), 64'd1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid();
        for (int g = 0; g < 100 && !out_valid; g++) step();
        check("out_valid_wait", 64'(out_valid), 64'd1);
    endtask

    task automatic drain(input int nb, input logic inv);
        out_ready = 1'b1;
        wait_valid();
        for (int b = 0; b < nb; b++) begin
            check("beat_valid", 64'(out_valid), 64'd1);
            check("beat_data", out_data, exp_q[b]);
            check("beat_last", 64'(out_last), 64'(b == 7));
            check("beat_inverse", 64'(out_inverse), 64'(inv));
            step();
        end
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_core_next", 64'(core_next), 64'd0);
        check("rst_core_inverse", 64'(core_inverse), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_core_in0", core_in[0], 64'd0);
        check("rst_core_in7", core_in[7], 64'd0);
        reset = 1'b1;
        out_ready = 1'b1;
        step();

        // Basic identity frame with latency checks
        base_next = n_next;
        base_len  = n_lenerr;
        send(8, 7, 0, 1'b0, 1'b0);
        check("basic_hold_ready", 64'(in_ready), 64'd0);
        step();
        check("basic_core_next", 64'(core_next), 64'd1);
        step();
        check("basic_core_in3", core_in[3], cx(3, 0));
        for (int s = 0; s < 5; s++) step();
        check("basic_valid_early", 64'(out_valid), 64'd0);
        step();
        check("basic_valid_t9", 64'(out_valid), 64'd1);
        for (int k = 0; k < 8; k++) exp_q[k] = cx(k, 0);
        drain(8, 1'b0);
        check("basic_valid_after", 64'(out_valid), 64'd0);
        check("basic_nnext", 64'(n_next - base_next), 64'd1);
        check("basic_lenerr", 64'(n_lenerr - base_len), 64'd0);

        // Early in_last at k=3 zero-pads the tail
        send(4, 3, 10, 1'b1, 1'b0);
        step();
        step();
        check("early_core_in0", core_in[0], cx(10, 1));
        check("early_core_in3", core_in[3], cx(13, 4));
        for (int j = 4; j < 8; j++) check("early_core_in_pad", core_in[j], 64'd0);
        for (int k = 0; k < 8; k++) exp_q[k] = (k < 4) ? cx(10 + k, k + 1) : cx(0, 0);
        drain(8, 1'b0);

        // Missing in_last: len_err pulse, frame still launches
        base_next = n_next;
        base_len  = n_lenerr;
        send(8, -1, 30, 1'b0, 1'b0);
        check("miss_len_err", 64'(len_err), 64'd1);
        step();
        check("miss_core_next", 64'(core_next), 64'd1);
        check("miss_len_err_once", 64'(len_err), 64'd0);
        for (int k = 0; k < 8; k++) exp_q[k] = cx(30 + k, 0);
        drain(8, 1'b0);
        check("miss_lenerr_cnt", 64'(n_lenerr - base_len), 64'd1);
        check("miss_nnext", 64'(n_next - base_next), 64'd1);

        // Inverse frame with 1/N scaling of a constant core result
        stub_const = 1'b1;
        send(8, 7, 0, 1'b0, 1'b1);
        step();
        check("inv_core_inverse", 64'(core_inverse), 64'd1);
        for (int k = 0; k < 8; k++) exp_q[k] = cx(32'h10, 32'hFFFF_FFF0);
        drain(8, 1'b1);
        stub_const = 1'b0;

        // Backpressure: frame A stalls in the output while frame B waits in HOLD
        out_ready = 1'b0;
        send(8, 7, 20, 1'b0, 1'b0);
        for (int g = 0; g < 100 && !out_valid; g++) step();
        check("bp_a_valid", 64'(out_valid), 64'd1);
        base_next = n_next;
        send(8, 7, 40, 1'b0, 1'b0);
        for (int s = 0; s < 12; s++) step();
        check("bp_hold_ready", 64'(in_ready), 64'd0);
        check("bp_no_launch", 64'(n_next - base_next), 64'd0);
        check("bp_stable_data", out_data, cx(20, 0));
        check("bp_stable_last", 64'(out_last), 64'd0);
        for (int k = 0; k < 8; k++) exp_q[k] = cx(20 + k, 0);
        drain(8, 1'b0);
        check("bp_no_early_launch", 64'(n_next - base_next), 64'd0);
        for (int g = 0; g < 20 && !core_next; g++) step();
        check("bp_second_launch", 64'(core_next), 64'd1);
        for (int k = 0; k < 8; k++) exp_q[k] = cx(40 + k, 0);
        drain(8, 1'b0);

        // Reset mid-drain at beat 3, then a spurious core_next_out while idle
        send(8, 7, 60, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) exp_q[k] = cx(60 + k, 0);
        drain(3, 1'b0);
        check("rst_mid_valid_pre", 64'(out_valid), 64'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_data", out_data, 64'd0);
        check("rst_mid_last", 64'(out_last), 64'd0);
        check("rst_mid_ready", 64'(in_ready), 64'd0);
        step();
        reset = 1'b1;
        for (int s = 0; s < 10; s++) step();
        check("rst_no_valid", 64'(out_valid), 64'd0);
        spur = 1'b1;
        step();
        spur = 1'b0;
        for (int s = 0; s < 12; s++) begin
            step();
            check("spur_no_valid", 64'(out_valid), 64'd0);
        end

        // Recovery frame after reset
        send(8, 7, 100, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) exp_q[k] = cx(100 + k, 0);
        drain(8, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft_frame_stream.md
# fft_frame_stream

Streaming frame adapter that sits between sample-serial datapaths in the convolution layer and the parallel-frame FFT/IFFT cores. It gathers `N_POINTS` complex samples from a valid/ready input stream into a frame and launches the core with the `next` / `next_out` protocol. It captures the transformed frame and replays it as a valid/ready output stream. Each frame carries a forward/inverse tag and can apply 1/N scaling on inverse frames. Input gathering of frame k+1 overlaps with core processing and output drain of frame k.

## Interface
- `N_POINTS`, 8 — points per frame; legal values 4, 8, 16.
- `DATA_W`, 32 — width of each real and imaginary part, two's complement.
- `SCALE_INV`, 1 — when 1, inverse-frame outputs are arithmetically shifted right by log2(`N_POINTS`).

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-low; clears all state.
- `in_valid`  in  1  — input sample valid.
- `in_ready`  out  1  — adapter accepts a sample.
- `in_data`  in  complex_t  — input sample.
- `in_last`  in  1  — final sample of frame; early assertion zero-pads the frame.
- `in_inverse`  in  1  — frame mode; sampled on the first accepted beat of a frame.
- `out_valid`  out  1  — output sample valid.
- `out_ready`  in  1  — downstream accepts.
- `out_data`  out  complex_t  — output sample, index 0 first.
- `out_last`  out  1  — high on index `N_POINTS`-1.
- `out_inverse`  out  1  — mode tag of the frame being drained.
- `len_err`  out  1  — one-cycle pulse when a frame reaches `N_POINTS` beats without `in_last`.
- `core_next`  out  1  — one-cycle launch pulse to the core.
- `core_inverse`  out  1  — selects the IFFT core; held from launch until capture.
- `core_in`  out  complex_t[`N_POINTS`]  — frame presented to the core.
- `core_next_out`  in  1  — core frame-ready pulse.
- `core_out`  in  complex_t[`N_POINTS`]  — core result frame.

## Operation
**Input FSM: FILL → HOLD → LAUNCH → PRESENT → FILL.**
- FILL
  - `in_ready`=1.
  - Each handshake writes `ibuf[cnt]` and increments `cnt`.
  - The frame closes on `in_last`, or on the handshake with `cnt`=`N_POINTS`-1.
  - On early close, entries cnt+1..N-1 are zeroed.
  - A close at `N_POINTS`-1 without `in_last` pulses `len_err` on the next cycle.
- HOLD
  - Waits while `inflight`=1.
  - Goes to LAUNCH when `inflight`=0 (same cycle if it is already clear).
- LAUNCH
  - `core_next`=1.
  - Sets `inflight` and latches `core_inverse`.
- PRESENT
  - `core_in` carries the frame; `ibuf` is untouched.
  - Then returns to FILL with `cnt`=0.

`core_in` is driven from `ibuf` at all times. The core samples it only in PRESENT.

**Output FSM: IDLE → CAPTURE → DRAIN → IDLE.**
- IDLE: on `core_next_out` with `inflight`=1, go to CAPTURE.
  - `core_next_out` with `inflight`=0 is ignored.
- CAPTURE: register `core_out` into `obuf`, applying scaling. Go to DRAIN with `ocnt`=0.
- DRAIN: `out_valid`=1 and `out_data`=`obuf[ocnt]`.
  - The handshake at `ocnt`=N-1 clears `inflight` and returns to IDLE.
- `out_data` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.

**Scaling**
- Applies only when `SCALE_INV`=1 and the frame is inverse.
- Real and imaginary parts are each shifted with `>>>` log2(N), truncating toward −∞.
- Forward frames pass unmodified. No saturation is needed.

## Timing
- Reset values: all outputs 0, `ibuf`/`obuf` 0, both FSMs in FILL/IDLE, `inflight`=0, counters 0.
- Closing handshake at cycle t, core free: `core_next` at t+2 (HOLD at t+1), `core_in` frame valid at t+3.
- Core latency L, meaning `core_next_out` L cycles after `core_next`:
  - CAPTURE at t+2+L+1;
  - first `out_valid` at t+2+L+2;
  - drain of N beats with `out_ready`=1 ends at t+L+N+3.
- The next launch is allowed no earlier than the cycle after the final drain handshake.
- One frame in core+obuf at a time; `ibuf` holds a second.
- A `core_next_out` that coincides with a LAUNCH cycle belongs to the previous frame. This cannot occur because launches are gated by `inflight`.
- Asynchronous reset in any state aborts every frame immediately, with no partial output.

## Structure
- `fft_pkg`: `complex_t` (`r`, `i`, each `DATA_W`), the `clog2`-based `LOG2N` constant helper, and an FSM state enum.
- Sub-module `fft_frame_serializer`: the output FSM, `obuf`, the scaling shifter and `out_*` generation.
- The top holds the input FSM, `ibuf` and `inflight`.

## Test plan
- **Identity stub, basic frame.** N=8, stub core with L=5 and `core_out`=`core_in`. Feed r=k, i=0 for k=0..7 with `in_last` on k=7. Required: one `core_next`, outputs r=0..7 in order, `out_last` on beat 7, `len_err`=0.
- **Early `in_last`.** Assert at k=3. Required: `core_in[4..7]`=0, 8 output beats, last 4 beats zero.
- **Missing `in_last`.** Omit it on k=7. Required: `len_err` pulses once and the frame still launches.
- **Inverse scaling.** `in_inverse`=1, `SCALE_INV`=1, N=8. Stub returns r=0x00000080, i=0xFFFFFF80. Required: out r=0x00000010, i=0xFFFFFFF0, `out_inverse`=1, `core_inverse`=1.
- **Backpressure.** Hold `out_ready`=0 through frame 1 while frame 2 fills. Required:
  - frame 2 sits in HOLD with `in_ready`=0;
  - no second `core_next` until the cycle after frame 1's beat-7 handshake;
  - no data lost.
- **Reset and spurious pulse.** Deassert `reset` mid-DRAIN at beat 3, and pulse `core_next_out` while idle. Required: outputs 0 immediately, no further `out_valid`, and the spurious pulse produces no output.
